cpu_step_ctrl: RTL and testbench

Execution-control stage sitting directly downstream of the board's button/switch debouncer and upstream of the CPU core's clock-enable input. It consumes the debounced switch levels and single-cycle button pulses, and turns them into a registered `cpu_en` strobe. The strobe supports four modes: halt, single/burst step, slow free-run and full-speed run. It also keeps a wrapping count of issued enables for the display path.

---
 rtl/cpu_step_ctrl_pkg.sv | 23 ++
 rtl/cpu_step_ctrl_if.sv | 20 ++
 rtl/cpu_step_ctrl_tick_div.sv | 25 ++
 rtl/cpu_step_ctrl.sv | 112 +++++++++++
 tb/tb_cpu_step_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared constants for the CPU execution-control stage: FSM state encodings,
// mode decode values and button/switch bit positions.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HALT      = 3'd0,
    S_STEP_IDLE = 3'd1,
    S_BURST     = 3'd2,
    S_SLOW      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  localparam int BTN_STEP  = 0;
  localparam int BTN_BURST = 1;
  localparam int BTN_CLR   = 2;
  localparam int SW_FREEZE = 7;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Control bundle between the debouncer/board side (master) and the
// execution-control stage (slave).
interface cpu_step_ctrl_if;
  logic [4:0]  btn_pulse;
  logic [7:0]  sw_ok;
  logic        cpu_en;
  logic        cpu_hold;
  logic [2:0]  state_out;
  logic [15:0] en_count;

  modport master (
    output btn_pulse, sw_ok,
    input  cpu_en, cpu_hold, state_out, en_count
  );

  modport slave (
    input  btn_pulse, sw_ok,
    output cpu_en, cpu_hold, state_out, en_count
  );
endinterface

// File: rtl/cpu_step_ctrl_tick_div.sv
// 32-bit SLOW-mode divider: counts while run is high, emits a one-cycle tick
// on the terminal count SLOW_DIV-1 and wraps to 0; clr zeroes, otherwise holds.
module tick_div #(
  parameter int unsigned SLOW_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [31:0] TERM = 32'(SLOW_DIV - 1);

  logic [31:0] cnt;

  assign tick = run && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= tick ? 32'd0 : cnt + 32'd1;
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: HALT / STEP+BURST / SLOW / RUN modes with freeze.
// cpu_en, state and status are registered one edge after the inputs are sampled.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned SLOW_DIV  = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  cpu_step_ctrl_if.slave  bus
);

  localparam logic [15:0] BURST_LOAD = 16'(BURST_LEN - 1);

  logic       freeze, btn_step, btn_burst, btn_clr;
  logic [1:0] mode;
  state_t     state, state_next;
  logic [15:0] burst_cnt, burst_cnt_d;
  logic       en_d, div_clr, div_run, tick;
  logic       cpu_en_q, cpu_hold_q;
  logic [2:0] state_out_q;
  logic [15:0] en_count_q;

  assign freeze    = bus.sw_ok[SW_FREEZE];
  assign mode      = bus.sw_ok[1:0];
  assign btn_step  = bus.btn_pulse[BTN_STEP];
  assign btn_burst = bus.btn_pulse[BTN_BURST];
  assign btn_clr   = bus.btn_pulse[BTN_CLR];

  wire unused_inputs = &{1'b0, bus.btn_pulse[4:3], bus.sw_ok[6:2]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_HALT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!freeze) begin
      case (mode)
        MODE_HALT: state_next = S_HALT;
        MODE_SLOW: state_next = S_SLOW;
        MODE_RUN:  state_next = S_RUN;
        default: begin
          if (state == S_BURST)
            state_next = (burst_cnt == 16'd0) ? S_STEP_IDLE : S_BURST;
          else if (state == S_STEP_IDLE && btn_burst)
            state_next = S_BURST;
          else
            state_next = S_STEP_IDLE;
        end
      endcase
    end
  end

  // Enable is derived from the next state so it lines up with the state register.
  always_comb begin
    en_d        = 1'b0;
    burst_cnt_d = burst_cnt;
    div_clr     = !freeze && (state != S_SLOW) && (state_next == S_SLOW);
    div_run     = !freeze && (state == S_SLOW) && (state_next == S_SLOW);
    if (!freeze) begin
      case (state_next)
        S_RUN:  en_d = 1'b1;
        S_SLOW: en_d = tick;
        S_BURST: begin
          if (state != S_BURST) begin
            en_d        = 1'b1;
            burst_cnt_d = BURST_LOAD;
          end else if (burst_cnt != 16'd0) begin
            en_d        = 1'b1;
            burst_cnt_d = burst_cnt - 16'd1;
          end
        end
        S_STEP_IDLE: en_d = (state == S_STEP_IDLE) && btn_step && !btn_burst;
        default: en_d = 1'b0;
      endcase
    end
  end

  tick_div #(.SLOW_DIV(SLOW_DIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .run  (div_run),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_en_q    <= 1'b0;
      cpu_hold_q  <= 1'b1;
      state_out_q <= 3'd0;
      burst_cnt   <= 16'd0;
      en_count_q  <= 16'd0;
    end else begin
      cpu_en_q    <= en_d;
      cpu_hold_q  <= (state_next != S_RUN);
      state_out_q <= state_next;
      burst_cnt   <= burst_cnt_d;
      if (btn_clr)       en_count_q <= 16'd0;
      else if (cpu_en_q) en_count_q <= en_count_q + 16'd1;
    end
  end

  assign bus.cpu_en    = cpu_en_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.state_out = state_out_q;
  assign bus.en_count  = en_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl; a queue holds the cycle numbers at which
// cpu_en is expected high and a negedge monitor pops one per observed enable.
module tb_cpu_step_ctrl;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   fails = 0;
  int   exp_q[$];

  cpu_step_ctrl_if bus();

  cpu_step_ctrl #(.BURST_LEN(16), .SLOW_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every observed enable must match the next scheduled enable cycle.
  always @(negedge clk) begin
    if (bus.cpu_en === 1'b1) begin
      int e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("en_cycle", cyc, e);
    end
  end

  task cyc_step(input logic [4:0] b, input logic [7:0] s);
    bus.btn_pulse = b;
    bus.sw_ok     = s;
    @(posedge clk);
    #1;
    bus.btn_pulse = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_pulse = 5'd0;
    bus.sw_ok     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", bus.cpu_en, 0);
    chk("rst_hold", bus.cpu_hold, 1);
    chk("rst_state", bus.state_out, 0);
    chk("rst_count", bus.en_count, 0);
    rst = 1'b0;

    // single step
    cyc_step(5'd0, 8'h01);
    chk("step_state", bus.state_out, 1);
    exp_q.push_back(cyc + 1);
    cyc_step(5'b00001, 8'h01);
    chk("step_en", bus.cpu_en, 1);
    cyc_step(5'd0, 8'h01);
    chk("step_en_off", bus.cpu_en, 0);
    chk("step_count", bus.en_count, 1);
    cyc_step(5'b00100, 8'h01);
    chk("clr_count", bus.en_count, 0);

    // burst with step and burst pressed together
    for (int i = 1; i <= 16; i++) exp_q.push_back(cyc + i);
    cyc_step(5'b00011, 8'h01);
    chk("burst_state", bus.state_out, 2);
    repeat (15) cyc_step(5'd0, 8'h01);
    chk("burst_last_en", bus.cpu_en, 1);
    cyc_step(5'd0, 8'h01);
    chk("burst_done_state", bus.state_out, 1);
    chk("burst_done_en", bus.cpu_en, 0);
    chk("burst_count", bus.en_count, 16);

    // burst aborted after 5 enables
    cyc_step(5'b00100, 8'h01);
    for (int i = 1; i <= 5; i++) exp_q.push_back(cyc + i);
    cyc_step(5'b00010, 8'h01);
    repeat (4) cyc_step(5'd0, 8'h01);
    cyc_step(5'd0, 8'h00);
    chk("abort_en", bus.cpu_en, 0);
    chk("abort_state", bus.state_out, 0);
    chk("abort_count", bus.en_count, 5);

    // slow mode, SLOW_DIV = 4
    cyc_step(5'b00100, 8'h00);
    exp_q.push_back(cyc + 5);
    exp_q.push_back(cyc + 9);
    exp_q.push_back(cyc + 13);
    cyc_step(5'd0, 8'h02);
    chk("slow_state", bus.state_out, 3);
    repeat (12) cyc_step(5'd0, 8'h02);
    chk("slow_en3", bus.cpu_en, 1);
    cyc_step(5'd0, 8'h00);
    chk("slow_count", bus.en_count, 3);

    // run, freeze, resume
    cyc_step(5'b00100, 8'h00);
    for (int i = 1; i <= 5; i++) exp_q.push_back(cyc + i);
    repeat (5) cyc_step(5'd0, 8'h03);
    chk("run_state", bus.state_out, 4);
    chk("run_hold", bus.cpu_hold, 0);
    repeat (8) cyc_step(5'd0, 8'h83);
    chk("frz_en", bus.cpu_en, 0);
    chk("frz_count", bus.en_count, 5);
    cyc_step(5'b00011, 8'h80);
    chk("frz_state", bus.state_out, 4);
    cyc_step(5'b00100, 8'h83);
    chk("frz_clr", bus.en_count, 0);
    for (int i = 1; i <= 3; i++) exp_q.push_back(cyc + i);
    repeat (3) cyc_step(5'd0, 8'h03);
    chk("resume_count", bus.en_count, 2);

    // wrap of en_count
    cyc_step(5'd0, 8'h00);
    cyc_step(5'b00100, 8'h00);
    for (int i = 0; i < 65535; i++) begin
      exp_q.push_back(cyc + 1);
      cyc_step(5'd0, 8'h03);
    end
    cyc_step(5'd0, 8'h00);
    chk("count_ffff", bus.en_count, 16'hFFFF);
    cyc_step(5'd0, 8'h01);
    exp_q.push_back(cyc + 1);
    cyc_step(5'b00001, 8'h01);
    cyc_step(5'd0, 8'h01);
    chk("count_wrap", bus.en_count, 0);

    // clear coinciding with an increment
    exp_q.push_back(cyc + 1);
    cyc_step(5'b00001, 8'h01);
    cyc_step(5'b00100, 8'h01);
    chk("clr_priority", bus.en_count, 0);

    // reset mid-run
    for (int i = 1; i <= 3; i++) exp_q.push_back(cyc + i);
    repeat (3) cyc_step(5'd0, 8'h03);
    rst = 1'b1;
    cyc_step(5'd0, 8'h03);
    chk("mrst_en", bus.cpu_en, 0);
    chk("mrst_state", bus.state_out, 0);
    chk("mrst_hold", bus.cpu_hold, 1);
    chk("mrst_count", bus.en_count, 0);
    rst = 1'b0;
    cyc_step(5'd0, 8'h00);
    chk("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
